// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline-control types, widths and the load-use hazard test.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  localparam int REG_W   = 5;   // architectural register index width
  localparam int CNT_W   = 8;   // multi-cycle countdown width (op length up to 255)
  localparam int STALL_W = 32;  // stall cycle counter width

  // Controller FSM encoding.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MDIV  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // A load in EX whose destination is read by the instruction in ID.
  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  function automatic logic load_use_hit(
    input logic             ex_is_load,
    input logic [REG_W-1:0] ex_rd,
    input logic [REG_W-1:0] id_rs1,
    input logic             id_use_rs1,
    input logic [REG_W-1:0] id_rs2,
    input logic             id_use_rs2
  );
    return ex_is_load && (ex_rd != '0) &&
           ((id_use_rs1 && (id_rs1 == ex_rd)) ||
            (id_use_rs2 && (id_rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard inputs from the pipeline and stall/flush controls back to it.
// Latency: n/a (wires only).
// Backpressure: n/a; master = pipeline datapath, slave = pipe_ctrl.
// Signals:
//   id_rs1/id_rs2, id_use_rs1/id_use_rs2 : sources read by the ID instruction
//   ex_rd, ex_is_load                    : destination / load flag of the EX instruction
//   br_taken, mdiv_start, mem_busy       : EX branch, multi-cycle start, memory not ready
//   pc_hold, if_id_hold, if_id_flush, id_exe_bubble, exe_hold, mdiv_done, stall_cnt : controls
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0]   id_rs1;
  logic [REG_W-1:0]   id_rs2;
  logic               id_use_rs1;
  logic               id_use_rs2;
  logic [REG_W-1:0]   ex_rd;
  logic               ex_is_load;
  logic               br_taken;
  logic               mdiv_start;
  logic               mem_busy;

  logic               pc_hold;
  logic               if_id_hold;
  logic               if_id_flush;
  logic               id_exe_bubble;
  logic               exe_hold;
  logic               mdiv_done;
  logic [STALL_W-1:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           br_taken, mdiv_start, mem_busy,
    input  pc_hold, if_id_hold, if_id_flush, id_exe_bubble, exe_hold,
           mdiv_done, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           br_taken, mdiv_start, mem_busy,
    output pc_hold, if_id_hold, if_id_flush, id_exe_bubble, exe_hold,
           mdiv_done, stall_cnt
  );

endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order pipeline hazard controller (load-use stall, branch flush, mul/div stall, memory freeze).
// Latency: controls are combinational from state and inputs (0 cycles); stall_cnt updates one edge later.
// Backpressure: mem_busy freezes PC, IF/ID and EX+ every cycle it is high; MDIV countdown keeps running.
// Ports: clk, rst (synchronous, active-high), bus (pipe_ctrl_if.slave).
// Config: define PIPE_CTRL_MDIV_EN to build the multi-cycle mul/div stall (MDIV state, counter,
//         mdiv_done). Without it mdiv_start is ignored and mdiv_done is tied to 0.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDIV_CYCLES = 32  // total stall cycles of one mul/div op, 2..255
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  state_t             state_q, state_d;
  logic [STALL_W-1:0] stall_q;
  logic               hit;

  logic pc_hold, if_id_hold, if_id_flush, id_exe_bubble, exe_hold, mdiv_done;

`ifdef PIPE_CTRL_MDIV_EN
  // Counts down the remaining MDIV-state cycles; the start cycle itself is the
  // first stall cycle, so the load value is MDIV_CYCLES-2.
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_mdiv;
  assign unused_mdiv = bus.mdiv_start ^ (MDIV_CYCLES > 0);
`endif

  assign hit = load_use_hit(bus.ex_is_load, bus.ex_rd, bus.id_rs1, bus.id_use_rs1,
                            bus.id_rs2, bus.id_use_rs2);

  always_comb begin
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_bubble = 1'b0;
    exe_hold      = 1'b0;
    mdiv_done     = 1'b0;
    state_d       = state_q;
`ifdef PIPE_CTRL_MDIV_EN
    cnt_d         = cnt_q;
`endif
    // Under reset every control stays low whatever the inputs are.
    if (!rst) begin
      case (state_q)
`ifdef PIPE_CTRL_MDIV_EN
        // The MDIV freeze is the same as the mem_busy freeze, so mem_busy needs
        // no separate handling here and the countdown runs through it.
        ST_MDIV: begin
          pc_hold    = 1'b1;
          if_id_hold = 1'b1;
          exe_hold   = 1'b1;
          if (cnt_q == '0) begin
            mdiv_done = 1'b1;
            state_d   = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
`endif
        ST_FLUSH: begin
          if (bus.mem_busy) begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
            exe_hold   = 1'b1;
          end else begin
            // Second slot behind a taken branch; hazards here belong to a wrong-path op.
            if_id_flush = 1'b1;
            state_d     = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.mem_busy) begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
            exe_hold   = 1'b1;
          end else if (bus.br_taken) begin
            if_id_flush   = 1'b1;
            id_exe_bubble = 1'b1;
            state_d       = ST_FLUSH;
`ifdef PIPE_CTRL_MDIV_EN
          end else if (bus.mdiv_start) begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
            exe_hold   = 1'b1;
            cnt_d      = CNT_W'(MDIV_CYCLES - 2);
            state_d    = ST_MDIV;
`endif
          end else if (hit) begin
            pc_hold       = 1'b1;
            if_id_hold    = 1'b1;
            id_exe_bubble = 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      stall_q <= '0;
`ifdef PIPE_CTRL_MDIV_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef PIPE_CTRL_MDIV_EN
      cnt_q   <= cnt_d;
`endif
      if (pc_hold) stall_q <= stall_q + STALL_W'(1);  // wraps naturally at 2^32
    end
  end

  assign bus.pc_hold       = pc_hold;
  assign bus.if_id_hold    = if_id_hold;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_exe_bubble = id_exe_bubble;
  assign bus.exe_hold      = exe_hold;
  assign bus.mdiv_done     = mdiv_done;
  assign bus.stall_cnt     = rst ? '0 : stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random checks of pipe_ctrl against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_ctrl;
  localparam int MDIV_CYCLES = 4;
`ifdef PIPE_CTRL_MDIV_EN
  localparam bit MDIV_EN = 1'b1;
`else
  localparam bit MDIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  pipe_ctrl_if bus();

  pipe_ctrl #(.MDIV_CYCLES(MDIV_CYCLES)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // mdiv_left : stall cycles still owed to a running mul/div op
  // flush_next: the cycle after a taken branch must squash IF/ID once more
  int          mdiv_left  = 0;
  bit          flush_next = 1'b0;
  logic [31:0] stall_exp  = 32'd0;

  always @(negedge clk) begin : model
    logic e_pc, e_ifh, e_fl, e_bub, e_exe, e_done;
    logic [31:0] e_stall;
    bit hit;
    e_pc = 0; e_ifh = 0; e_fl = 0; e_bub = 0; e_exe = 0; e_done = 0;
    hit = bus.ex_is_load && bus.ex_rd != 5'd0 &&
          ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
           (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
    if (rst) begin
      e_stall    = 32'd0;
      mdiv_left  = 0;
      flush_next = 1'b0;
      stall_exp  = 32'd0;
    end else begin
      e_stall = stall_exp;
      if (mdiv_left > 0) begin
        e_pc = 1; e_ifh = 1; e_exe = 1;
        mdiv_left--;
        e_done = (mdiv_left == 0);
      end else if (bus.mem_busy) begin
        e_pc = 1; e_ifh = 1; e_exe = 1;
      end else if (flush_next) begin
        e_fl = 1;
        flush_next = 1'b0;
      end else if (bus.br_taken) begin
        e_fl = 1; e_bub = 1;
        flush_next = 1'b1;
      end else if (MDIV_EN && bus.mdiv_start) begin
        e_pc = 1; e_ifh = 1; e_exe = 1;
        mdiv_left = MDIV_CYCLES - 1;
      end else if (hit) begin
        e_pc = 1; e_ifh = 1; e_bub = 1;
      end
      if (e_pc) stall_exp = stall_exp + 32'd1;
    end
    chk("pc_hold",       {31'd0, bus.pc_hold},       {31'd0, e_pc});
    chk("if_id_hold",    {31'd0, bus.if_id_hold},    {31'd0, e_ifh});
    chk("if_id_flush",   {31'd0, bus.if_id_flush},   {31'd0, e_fl});
    chk("id_exe_bubble", {31'd0, bus.id_exe_bubble}, {31'd0, e_bub});
    chk("exe_hold",      {31'd0, bus.exe_hold},      {31'd0, e_exe});
    chk("mdiv_done",     {31'd0, bus.mdiv_done},     {31'd0, e_done});
    chk("stall_cnt",     bus.stall_cnt,              e_stall);
    chk("hold_flush_excl", {31'd0, bus.if_id_hold & bus.if_id_flush}, 32'd0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    rst            = 1'b0;
    bus.id_rs1     = 5'd0;
    bus.id_rs2     = 5'd0;
    bus.id_use_rs1 = 1'b0;
    bus.id_use_rs2 = 1'b0;
    bus.ex_rd      = 5'd0;
    bus.ex_is_load = 1'b0;
    bus.br_taken   = 1'b0;
    bus.mdiv_start = 1'b0;
    bus.mem_busy   = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    next_cycle(); rst = 1'b1; look();
  endtask

  // Packed view of the six single-bit controls: pc, ifh, fl, bub, exe, done.
  function automatic logic [5:0] ctl();
    return {bus.pc_hold, bus.if_id_hold, bus.if_id_flush,
            bus.id_exe_bubble, bus.exe_hold, bus.mdiv_done};
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    look();

    // Reset dominates every input.
    next_cycle();
    rst = 1'b1;
    bus.ex_is_load = 1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1;
    bus.br_taken = 1; bus.mdiv_start = 1; bus.mem_busy = 1;
    look();
    chk("rst_ctl",   {26'd0, ctl()}, 32'd0);
    chk("rst_stall", bus.stall_cnt,  32'd0);

    // Load-use on rs1: exactly one stall cycle.
    do_reset();
    next_cycle();
    bus.ex_is_load = 1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1;
    look();
    chk("lu_ctl", {26'd0, ctl()}, {26'd0, 6'b110100});
    next_cycle(); look();
    chk("lu_after_ctl",   {26'd0, ctl()}, 32'd0);
    chk("lu_after_stall", bus.stall_cnt,  32'd1);

    // Load into x0 read as rs1 = x0: no hazard.
    do_reset();
    next_cycle();
    bus.ex_is_load = 1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_use_rs1 = 1;
    look();
    chk("x0_ctl", {26'd0, ctl()}, 32'd0);
    next_cycle(); look();
    chk("x0_stall", bus.stall_cnt, 32'd0);

    // Taken branch: flush+bubble, then flush only (hazard ignored), then idle.
    do_reset();
    next_cycle(); bus.br_taken = 1; look();
    chk("br_c0", {26'd0, ctl()}, {26'd0, 6'b001100});
    next_cycle();
    bus.br_taken = 1; bus.ex_is_load = 1; bus.ex_rd = 5'd7; bus.id_rs2 = 5'd7; bus.id_use_rs2 = 1;
    look();
    chk("br_c1", {26'd0, ctl()}, {26'd0, 6'b001000});
    next_cycle(); look();
    chk("br_c2",    {26'd0, ctl()}, 32'd0);
    chk("br_stall", bus.stall_cnt,  32'd0);

    // mem_busy alone in RUN freezes and counts.
    do_reset();
    next_cycle(); bus.mem_busy = 1; look();
    chk("mb_ctl", {26'd0, ctl()}, {26'd0, 6'b110010});
    next_cycle(); look();
    chk("mb_stall", bus.stall_cnt, 32'd1);

`ifdef PIPE_CTRL_MDIV_EN
    // Mul/div: four stall cycles, done on the fourth.
    do_reset();
    next_cycle(); bus.mdiv_start = 1; look();
    chk("md_c0", {26'd0, ctl()}, {26'd0, 6'b110010});
    for (int i = 1; i < 3; i++) begin
      next_cycle(); look();
      chk("md_mid", {26'd0, ctl()}, {26'd0, 6'b110010});
    end
    next_cycle(); look();
    chk("md_c3", {26'd0, ctl()}, {26'd0, 6'b110011});
    next_cycle(); look();
    chk("md_c4",    {26'd0, ctl()}, 32'd0);
    chk("md_stall", bus.stall_cnt,  32'd4);

    // mem_busy during the MDIV cycles does not stretch the op.
    do_reset();
    next_cycle(); bus.mdiv_start = 1; look();
    next_cycle(); bus.mem_busy = 1; look();
    next_cycle(); bus.mem_busy = 1; look();
    next_cycle(); bus.mem_busy = 1; look();
    chk("mdmb_c3", {26'd0, ctl()}, {26'd0, 6'b110011});
    next_cycle(); bus.mem_busy = 1; look();
    chk("mdmb_freeze", {26'd0, ctl()}, {26'd0, 6'b110010});
    next_cycle(); look();
    chk("mdmb_idle",  {26'd0, ctl()}, 32'd0);
    chk("mdmb_stall", bus.stall_cnt,  32'd5);

    // Reset in the second mul/div cycle abandons the op silently.
    do_reset();
    next_cycle(); bus.mdiv_start = 1; look();
    next_cycle(); rst = 1'b1; look();
    chk("mdrst_c1", {26'd0, ctl()}, 32'd0);
    next_cycle(); look();
    chk("mdrst_c2",    {26'd0, ctl()}, 32'd0);
    chk("mdrst_stall", bus.stall_cnt,  32'd0);
`else
    // Without the mul/div option mdiv_start has no effect.
    do_reset();
    next_cycle(); bus.mdiv_start = 1; look();
    chk("nomd_ctl", {26'd0, ctl()}, 32'd0);
    next_cycle(); look();
    chk("nomd_stall", bus.stall_cnt, 32'd0);
`endif

    // Random traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      rst            = ($urandom_range(0, 99) == 0);
      bus.id_rs1     = 5'($urandom_range(0, 3));
      bus.id_rs2     = 5'($urandom_range(0, 3));
      bus.id_use_rs1 = 1'($urandom_range(0, 1));
      bus.id_use_rs2 = 1'($urandom_range(0, 1));
      bus.ex_rd      = 5'($urandom_range(0, 3));
      bus.ex_is_load = 1'($urandom_range(0, 1));
      bus.br_taken   = ($urandom_range(0, 7) == 0);
      bus.mdiv_start = ($urandom_range(0, 11) == 0);
      bus.mem_busy   = ($urandom_range(0, 5) == 0);
      look();
    end

    next_cycle(); look();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MDIV_CYCLES, default 32: total stall cycles for one multi-cycle mul/div op (legal 2..255).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 SHALL have port id_use_rs1, id_use_rs2  input  1 each  ID instruction reads that source.
REQ-006 SHALL have port ex_rd  input  5  destination register of the instruction in EX.
REQ-007 SHALL have port ex_is_load  input  1  EX instruction is a load.
REQ-008 SHALL have port br_taken  input  1  taken branch/jump resolved in EX this cycle.
REQ-009 SHALL have port mdiv_start  input  1  multi-cycle op entered EX this cycle.
REQ-010 SHALL have port mem_busy  input  1  data memory not ready; whole pipe must freeze.
REQ-011 SHALL have port pc_hold  output  1  PC keeps its value.
REQ-012 SHALL have port if_id_hold  output  1  IF/ID register keeps its value.
REQ-013 SHALL have port if_id_flush  output  1  IF/ID register loads a NOP.
REQ-014 SHALL have port id_exe_bubble  output  1  drives ID/EX hold; ID/EX loads all-zero bubble.
REQ-015 SHALL have port exe_hold  output  1  EX and later stage registers keep their values.
REQ-016 SHALL have port mdiv_done  output  1  one-cycle pulse on the last multi-cycle stall cycle.
REQ-017 SHALL have port stall_cnt  output  32  count of cycles with pc_hold=1.

Function
REQ-018 SHALL implement FSM states RUN, MDIV, FLUSH; outputs are combinational from state and inputs; no input-to-output register latency.
REQ-019 SHALL give priority per cycle: mem_busy > MDIV state > FLUSH state > br_taken > mdiv_start > load-use.
REQ-020 SHALL, when mem_busy=1 in any state: pc_hold=if_id_hold=exe_hold=1, flush/bubble=0, state unchanged, except the MDIV counter still decrements.
REQ-021 SHALL detect load-use as ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)); in RUN: pc_hold=if_id_hold=id_exe_bubble=1 for that cycle only, state stays RUN.
REQ-022 SHALL, on br_taken in RUN: if_id_flush=id_exe_bubble=1, pc_hold=0; next state FLUSH.
REQ-023 SHALL, in FLUSH: if_id_flush=1, all other outputs 0, load-use and br_taken ignored; next state RUN.
REQ-024 SHALL, on mdiv_start in RUN: pc_hold=if_id_hold=exe_hold=1; load counter MDIV_CYCLES-2; next state MDIV.
REQ-025 SHALL, in MDIV: pc_hold=if_id_hold=exe_hold=1; counter decrements; at counter 0 pulse mdiv_done and return to RUN; total stall = MDIV_CYCLES cycles.
REQ-026 SHALL increment stall_cnt by 1 each cycle pc_hold=1; wrap from 0xFFFFFFFF to 0.
REQ-027 SHALL never assert if_id_hold and if_id_flush in the same cycle.

Reset
REQ-028 SHALL, while rst=1: state RUN, MDIV counter 0, stall_cnt 0, all outputs 0 regardless of inputs.
REQ-029 SHALL abandon MDIV or FLUSH immediately on rst, with no mdiv_done pulse.

Configuration
REQ-030 SHALL with PIPE_CTRL_MDIV_EN defined implement MDIV state, counter and mdiv_done per REQ-024/025.
REQ-031 SHALL without PIPE_CTRL_MDIV_EN ignore mdiv_start, omit MDIV state and counter, tie mdiv_done to 0.

Structure
REQ-032 SHALL place FSM state encoding (RUN=0, MDIV=1, FLUSH=2, 2 bits) in the shared pipeline package.
REQ-033 SHALL be a single module; no sub-module.

Verification
REQ-034 SHALL cover: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle of pc_hold=if_id_hold=id_exe_bubble=1, stall_cnt +1.
REQ-035 SHALL cover: ex_rd=0 load with id_rs1=0 -> no stall.
REQ-036 SHALL cover: br_taken pulse -> cycle 0 if_id_flush+id_exe_bubble, cycle 1 if_id_flush only, cycle 2 idle.
REQ-037 SHALL cover (MDIV_EN, MDIV_CYCLES=4): mdiv_start -> 4 cycles exe_hold=1, mdiv_done on 4th, stall_cnt +4.
REQ-038 SHALL cover: mem_busy=1 for 3 cycles during MDIV (MDIV_CYCLES=4) -> MDIV still exits after 4 total cycles; freeze continues while mem_busy.
REQ-039 SHALL cover: rst asserted in 2nd MDIV cycle -> next cycle all outputs 0, stall_cnt 0, no mdiv_done.
